// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Takes one registered EX record at a time,
// performs an RV64 load or store over a req/gnt/rvalid data-memory port, and
// emits a single-cycle registered writeback record. EX is back-pressured
// through o_mem_ready. The rd of a writing record still in flight is exported
// for hazard detection.
//
// Handshakes: the EX record is taken on a cycle where i_valid and o_mem_ready
// are both 1. A memory request stays up with its address, byte enables, write
// data and write flag unchanged until a cycle where o_dmem_req and i_dmem_gnt
// are both 1. Load data is taken only when i_dmem_rvalid is 1 in a cycle after
// the grant cycle; rvalid at any other time is ignored.
module mem_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_is_load,
  input  logic              i_is_store,
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [REG_AW-1:0] i_rd_addr,
  input  logic              i_rf_wr_en,
  output logic              o_mem_ready,
  output logic [REG_AW-1:0] o_mem_rd,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [XLEN-1:0]   o_dmem_addr,
  output logic [7:0]        o_dmem_be,
  output logic [XLEN-1:0]   o_dmem_wdata,
  input  logic              i_dmem_gnt,
  input  logic              i_dmem_rvalid,
  input  logic [XLEN-1:0]   i_dmem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_we,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_misaligned,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t            state;

  // Fields of the memory record currently in flight.
  logic              held_is_load;
  logic [2:0]        held_funct3;
  logic [2:0]        held_off;
  logic [REG_AW-1:0] held_rd;
  logic              held_wr_en;

  logic              is_mem;
  logic [2:0]        off;
  logic              misaligned;
  logic [7:0]        be_c;
  logic [XLEN-1:0]   wdata_c;

  // Shift the addressed bytes down to bit 0 and sign/zero extend by funct3.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                               input logic [2:0]      lane,
                                               input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {lane, 3'b000};
    case (f3)
      3'd0:    res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'd1:    res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'd2:    res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      3'd4:    res = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'd5:    res = {{(XLEN-16){1'b0}}, sh[15:0]};
      3'd6:    res = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Decode access size from the incoming record: alignment, lanes, store data.
  always_comb begin
    is_mem     = i_is_load | i_is_store;
    off        = i_addr[2:0];
    misaligned = 1'b0;
    be_c       = 8'h00;
    case (i_funct3[1:0])
      2'd0: begin
        misaligned = 1'b0;
        be_c       = 8'h01 << off;
      end
      2'd1: begin
        misaligned = off[0];
        be_c       = 8'h03 << off;
      end
      2'd2: begin
        misaligned = |off[1:0];
        be_c       = 8'h0F << off;
      end
      default: begin
        misaligned = |off;
        be_c       = 8'hFF;
      end
    endcase
    wdata_c = i_wdata << {off, 3'b000};
  end

  assign o_mem_ready = (state == IDLE);
  assign o_mem_rd    = ((state != IDLE) && held_wr_en) ? held_rd : '0;
  assign dbg_state   = state;

  // Stage FSM: accepts records, runs the memory handshake, emits writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      held_is_load <= 1'b0;
      held_funct3  <= '0;
      held_off     <= '0;
      held_rd      <= '0;
      held_wr_en   <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_be    <= '0;
      o_dmem_wdata <= '0;
      o_wb_valid   <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_rd      <= '0;
      o_wb_data    <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_wb_valid   <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (!is_mem) begin
              o_wb_valid <= 1'b1;
              o_wb_we    <= i_rf_wr_en;
              o_wb_rd    <= i_rd_addr;
              o_wb_data  <= i_addr;
            end else if (misaligned) begin
              o_wb_valid   <= 1'b1;
              o_wb_we      <= 1'b0;
              o_wb_rd      <= i_rd_addr;
              o_wb_data    <= '0;
              o_misaligned <= 1'b1;
            end else begin
              state        <= REQ;
              held_is_load <= i_is_load;
              held_funct3  <= i_funct3;
              held_off     <= off;
              held_rd      <= i_rd_addr;
              held_wr_en   <= i_rf_wr_en & i_is_load;
              o_dmem_req   <= 1'b1;
              o_dmem_we    <= ~i_is_load;
              o_dmem_addr  <= {i_addr[XLEN-1:3], 3'b000};
              o_dmem_be    <= be_c;
              o_dmem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (i_dmem_gnt) begin
            o_dmem_req <= 1'b0;
            if (held_is_load) begin
              state <= RSP;
            end else begin
              state      <= IDLE;
              o_wb_valid <= 1'b1;
              o_wb_we    <= 1'b0;
              o_wb_rd    <= held_rd;
              o_wb_data  <= '0;
            end
          end
        end
        RSP: begin
          if (i_dmem_rvalid) begin
            state      <= IDLE;
            o_wb_valid <= 1'b1;
            o_wb_we    <= held_wr_en;
            o_wb_rd    <= held_rd;
            o_wb_data  <= load_ext(held_funct3, held_off, i_dmem_rdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
